// File: rtl/mod_addsub_arbiter_if.sv
// One requester port of the add/sub arbiter: operand request, grant,
// result delivery and acknowledge.
interface mod_addsub_arbiter_if;
    logic       req;
    logic       s;
    logic [3:0] x;
    logic [3:0] y;
    logic       gnt;
    logic       done;
    logic [3:0] z;
    logic       ack;

    // Requester side drives the request and consumes the result
    modport master (
        output req, s, x, y, ack,
        input  gnt, done, z
    );

    // Arbiter side grants the request and returns the result
    modport slave (
        input  req, s, x, y, ack,
        output gnt, done, z
    );
endinterface

// File: rtl/mod_addsub_arbiter.sv
// Round-robin sharing controller for a single 4-bit modular add/sub
// datapath. Two requesters take turns; operands are registered, the
// datapath settles for one cycle, and the result is held for the owner
// until it acknowledges.

// Combinational 4-bit modular adder/subtractor: s=0 adds, s=1 subtracts,
// both wrap modulo 16.
module CIRCUIT (
    input  logic       s,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] z
);
    assign z = s ? (x - y) : (x + y);
endmodule

module mod_addsub_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    mod_addsub_arbiter_if.slave  a,
    mod_addsub_arbiter_if.slave  b,
    output logic                 busy,
    output logic [7:0]           op_count
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Owner encoding: 0 = port A, 1 = port B
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       op_s;
    logic [3:0] op_x;
    logic [3:0] op_y;
    logic [3:0] circ_z;
    logic       pick_b;
    logic       owner_ack;

    // B wins when it is the only requester, or on a tie when A was served last
    assign pick_b = b.req && (!a.req || (last_owner == OWNER_A));

    // Only the current owner's acknowledge can close the response phase
    assign owner_ack = (owner == OWNER_B) ? b.ack : a.ack;

    CIRCUIT u_circuit (
        .s (op_s),
        .x (op_x),
        .y (op_y),
        .z (circ_z)
    );

    // Arbitration FSM with all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWNER_B;
            last_owner <= OWNER_B;
            op_s       <= 1'b0;
            op_x       <= 4'd0;
            op_y       <= 4'd0;
            a.gnt      <= 1'b0;
            a.done     <= 1'b0;
            a.z        <= 4'd0;
            b.gnt      <= 1'b0;
            b.done     <= 1'b0;
            b.z        <= 4'd0;
            busy       <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            a.gnt <= 1'b0;
            b.gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (a.req || b.req) begin
                        owner <= pick_b;
                        if (pick_b) begin
                            op_s  <= b.s;
                            op_x  <= b.x;
                            op_y  <= b.y;
                            b.gnt <= 1'b1;
                        end else begin
                            op_s  <= a.s;
                            op_x  <= a.x;
                            op_y  <= a.y;
                            a.gnt <= 1'b1;
                        end
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner == OWNER_B) begin
                        b.z    <= circ_z;
                        b.done <= 1'b1;
                    end else begin
                        a.z    <= circ_z;
                        a.done <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_ack) begin
                        a.done     <= 1'b0;
                        b.done     <= 1'b0;
                        last_owner <= owner;
                        op_count   <= op_count + 8'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
